// File: rtl/ps2_scancode_receiver.sv
// PS/2 keyboard receiver: synchronise and de-glitch the pins, deframe 11-bit frames and
// fold E0/F0 prefixes into single key events held in a one-entry output register.
module ps2_scancode_receiver #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int TIMEOUT_US  = 1000,
    parameter int FILTER_LEN  = 8
) (
    input  logic       ACLK,
    input  logic       ARESET,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       key_valid,
    input  logic       key_ready,
    output logic [7:0] key_code,
    output logic       key_extended,
    output logic       key_release,
    output logic       err_parity,
    output logic       err_frame,
    output logic       err_timeout,
    output logic       err_overrun,
    output logic       busy
);

    localparam int TMO_LIMIT = CLK_FREQ_HZ / 1_000_000 * TIMEOUT_US;
    localparam int TW        = $clog2(TMO_LIMIT + 1);
    localparam int FW        = $clog2(FILTER_LEN + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t          state, state_nxt;
    logic            clk_s1, clk_s2, dat_s1, dat_s2;
    logic            filt_lvl, filt_prev;
    logic [FW-1:0]   filt_cnt;
    logic            fall;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;
    logic            par_ok;
    logic [TW-1:0]   tmo_cnt;
    logic            ext_flag, rel_flag;
    logic            byte_ok, par_err_c, frm_err_c, tmo_err_c;
    logic            ev_vld, can_load;

    // Synchronisers reset to the idle-high line level so release never looks like an edge.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            clk_s1    <= 1'b1;
            clk_s2    <= 1'b1;
            dat_s1    <= 1'b1;
            dat_s2    <= 1'b1;
            filt_lvl  <= 1'b1;
            filt_prev <= 1'b1;
            filt_cnt  <= '0;
        end else begin
            clk_s1    <= ps2_clk;
            clk_s2    <= clk_s1;
            dat_s1    <= ps2_data;
            dat_s2    <= dat_s1;
            filt_prev <= filt_lvl;
            if (clk_s2 == filt_lvl) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                filt_lvl <= clk_s2;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    assign fall = filt_prev & ~filt_lvl;

    always_comb begin
        state_nxt = state;
        byte_ok   = 1'b0;
        par_err_c = 1'b0;
        frm_err_c = 1'b0;
        tmo_err_c = 1'b0;
        // A fall landing on the limit cycle wins over the timeout.
        if (state != IDLE && !fall && tmo_cnt == TW'(TMO_LIMIT)) begin
            state_nxt = IDLE;
            tmo_err_c = 1'b1;
        end else if (fall) begin
            case (state)
                IDLE: begin
                    if (dat_s2) frm_err_c = 1'b1;
                    else        state_nxt = DATA;
                end
                DATA: begin
                    if (bit_cnt == 3'd7) state_nxt = PARITY;
                end
                PARITY: state_nxt = STOP;
                STOP: begin
                    state_nxt = IDLE;
                    if (!dat_s2)     frm_err_c = 1'b1;
                    else if (!par_ok) par_err_c = 1'b1;
                    else             byte_ok   = 1'b1;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            par_ok  <= 1'b0;
            tmo_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (fall) begin
                case (state)
                    IDLE:   bit_cnt <= '0;
                    DATA: begin
                        shreg   <= {dat_s2, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    PARITY: par_ok <= ^{shreg, dat_s2};
                    default: ;
                endcase
            end
            if (state == IDLE || fall || state_nxt == IDLE) tmo_cnt <= '0;
            else                                           tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign ev_vld   = byte_ok && shreg != 8'hE0 && shreg != 8'hF0;
    assign can_load = !key_valid || key_ready;
    assign busy     = (state != IDLE);

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            ext_flag     <= 1'b0;
            rel_flag     <= 1'b0;
            key_valid    <= 1'b0;
            key_code     <= '0;
            key_extended <= 1'b0;
            key_release  <= 1'b0;
            err_parity   <= 1'b0;
            err_frame    <= 1'b0;
            err_timeout  <= 1'b0;
            err_overrun  <= 1'b0;
        end else begin
            err_parity  <= par_err_c;
            err_frame   <= frm_err_c;
            err_timeout <= tmo_err_c;
            err_overrun <= ev_vld && !can_load;

            if (par_err_c || frm_err_c || tmo_err_c) begin
                ext_flag <= 1'b0;
                rel_flag <= 1'b0;
            end else if (byte_ok) begin
                if (shreg == 8'hE0) begin
                    ext_flag <= 1'b1;
                end else if (shreg == 8'hF0) begin
                    rel_flag <= 1'b1;
                end else begin
                    ext_flag <= 1'b0;
                    rel_flag <= 1'b0;
                end
            end

            if (ev_vld && can_load) begin
                key_valid    <= 1'b1;
                key_code     <= shreg;
                key_extended <= ext_flag;
                key_release  <= rel_flag;
            end else if (key_valid && key_ready) begin
                key_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_scancode_receiver.sv
// Bench for ps2_scancode_receiver: PS/2 frame driver, event scoreboard and error-pulse counters.
module tb_ps2_scancode_receiver;

    localparam int HALF = 30;

    logic       ACLK;
    logic       ARESET;
    logic       ps2_clk;
    logic       ps2_data;
    logic       key_valid;
    logic       key_ready;
    logic [7:0] key_code;
    logic       key_extended;
    logic       key_release;
    logic       err_parity;
    logic       err_frame;
    logic       err_timeout;
    logic       err_overrun;
    logic       busy;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       rel;
    } evt_t;

    evt_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_par = 0;
    int   n_frm = 0;
    int   n_tmo = 0;
    int   n_ovr = 0;
    int   n_busy = 0;

    ps2_scancode_receiver #(
        .CLK_FREQ_HZ(10_000_000),
        .TIMEOUT_US (100),
        .FILTER_LEN (8)
    ) dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .key_code    (key_code),
        .key_extended(key_extended),
        .key_release (key_release),
        .err_parity  (err_parity),
        .err_frame   (err_frame),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun),
        .busy        (busy)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Error counters tally high cycles, so a stretched pulse shows up as an extra count.
    always @(negedge ACLK) begin
        if (!ARESET) begin
            if (err_parity)  n_par++;
            if (err_frame)   n_frm++;
            if (err_timeout) n_tmo++;
            if (err_overrun) n_ovr++;
            if (busy)        n_busy++;
            if (key_valid && key_ready) begin
                if (exp_q.size() == 0) begin
                    check("evt_unexpected_qdepth", exp_q.size(), 1);
                end else begin
                    evt_t e;
                    e = exp_q.pop_front();
                    check("evt_code", key_code, e.code);
                    check("evt_ext", key_extended, e.ext);
                    check("evt_rel", key_release, e.rel);
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge ACLK);
        #1;
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        wait_cyc(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic flip_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(~^b ^ flip_par);
        ps2_bit(1'b1);
        ps2_data = 1'b1;
        wait_cyc(20);
    endtask

    task automatic push(input logic [7:0] c, input logic e, input logic r);
        evt_t ev;
        ev.code = c;
        ev.ext  = e;
        ev.rel  = r;
        exp_q.push_back(ev);
    endtask

    initial begin
        int snap_busy, snap_frm;
        logic [7:0] b29;
        ARESET    = 1'b1;
        ps2_clk   = 1'b1;
        ps2_data  = 1'b1;
        key_ready = 1'b1;
        wait_cyc(4);
        check("rst_key_valid", key_valid, 0);
        check("rst_key_code", key_code, 0);
        check("rst_flags", {key_extended, key_release}, 0);
        check("rst_errs", {err_parity, err_frame, err_timeout, err_overrun}, 0);
        check("rst_busy", busy, 0);
        ARESET = 1'b0;
        wait_cyc(5);

        push(8'h1C, 1'b0, 1'b0);
        send_byte(8'h1C, 1'b0);
        check("plain_no_errs", n_par + n_frm + n_tmo + n_ovr, 0);

        push(8'h75, 1'b1, 1'b1);
        send_byte(8'hE0, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h75, 1'b0);
        push(8'h75, 1'b0, 1'b0);
        send_byte(8'h75, 1'b0);

        send_byte(8'h1C, 1'b1);
        check("parity_pulse", n_par, 1);
        push(8'h1C, 1'b0, 1'b1);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h1C, 1'b0);

        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(i[0]);
        ps2_data = 1'b1;
        check("tmo_busy_before", busy, 1);
        wait_cyc(1200);
        check("tmo_pulse", n_tmo, 1);
        check("tmo_busy_after", busy, 0);
        push(8'h32, 1'b0, 1'b0);
        send_byte(8'h32, 1'b0);

        key_ready = 1'b0;
        push(8'h1C, 1'b0, 1'b0);
        send_byte(8'h1C, 1'b0);
        send_byte(8'h32, 1'b0);
        check("ovr_pulse", n_ovr, 1);
        check("ovr_key_valid", key_valid, 1);
        check("ovr_key_code", key_code, 8'h1C);
        key_ready = 1'b1;
        wait_cyc(3);
        check("ovr_drained", key_valid, 0);

        snap_busy = n_busy;
        snap_frm  = n_frm;
        ps2_clk = 1'b0;
        wait_cyc(7);
        ps2_clk = 1'b1;
        wait_cyc(40);
        check("glitch_busy_cycles", n_busy - snap_busy, 0);
        check("glitch_no_frame_err", n_frm - snap_frm, 0);

        b29 = 8'h29;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(b29[i]);
        check("midframe_busy", busy, 1);
        ARESET = 1'b1;
        wait_cyc(2);
        check("arst_busy", busy, 0);
        check("arst_outputs", {key_valid, key_code, key_extended, key_release}, 0);
        check("arst_errs", {err_parity, err_frame, err_timeout, err_overrun}, 0);
        ARESET = 1'b0;
        ps2_data = 1'b1;
        wait_cyc(10);
        push(8'h29, 1'b0, 1'b0);
        send_byte(8'h29, 1'b0);

        wait_cyc(50);
        check("queue_drained", exp_q.size(), 0);
        check("total_parity", n_par, 1);
        check("total_frame", n_frm, 0);
        check("total_timeout", n_tmo, 1);
        check("total_overrun", n_ovr, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
